// File: rtl/wb_ic_pkg.sv
// Shared definitions for the parametrised Wishbone interconnect.
package wb_ic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } ic_state_t;

    localparam logic [7:0] ERR_DATA_DEF = 8'hEE;

    // Slave index assignments used by the board-level integration.
    localparam int SLV_LED     = 0;
    localparam int SLV_VIDEO   = 1;
    localparam int SLV_CHARRAM = 2;

endpackage

// File: rtl/wb_ic_watchdog.sv
// Ack timeout watchdog: a down-counter reloaded while the interconnect is not
// waiting on a slave, and decremented while it is. The terminal count is
// reached on the TIMEOUT_CYC-th waiting cycle, where timeout is raised.
module wb_ic_watchdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // Reload on clear, count down while enabled, park at the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= LOAD_VAL;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign timeout = enable && (cnt == '0);

endmodule

// File: rtl/wb_interconnect_n.sv
// Single-master Wishbone classic interconnect with address decode to
// NUM_SLAVES ports, error termination for unmapped addresses, ack timeout
// watchdog, saturating error counter and last-error address capture.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for master cyc&stb; captures adr/dat/we and index
// REQ   | selected slave strobed, waiting for its ack or timeout
// RESP  | one-cycle master ack with latched slave data
// ERR   | one-cycle master ack+err with ERR_DATA, error logged
module wb_interconnect_n
    import wb_ic_pkg::*;
#(
    parameter int                NUM_SLAVES  = 4,
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 8,
    parameter int                SEL_W       = 4,
    parameter int                TIMEOUT_CYC = 255,
    parameter logic [DATA_W-1:0] ERR_DATA    = ERR_DATA_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            wb_adr_i,
    input  logic [DATA_W-1:0]            wb_dat_i,
    output logic [DATA_W-1:0]            wb_dat_o,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    input  logic                         wb_we_i,
    output logic                         wb_ack_o,
    output logic                         wb_err_o,
    output logic [NUM_SLAVES*ADDR_W-1:0] s_wb_adr_o,
    output logic [NUM_SLAVES*DATA_W-1:0] s_wb_dat_o,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_wb_dat_i,
    output logic [NUM_SLAVES-1:0]        s_wb_cyc_o,
    output logic [NUM_SLAVES-1:0]        s_wb_stb_o,
    output logic [NUM_SLAVES-1:0]        s_wb_we_o,
    input  logic [NUM_SLAVES-1:0]        s_wb_ack_i,
    output logic [7:0]                   err_count_o,
    output logic [ADDR_W-1:0]            last_err_adr_o
);

    ic_state_t         state, state_nxt;
    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] dat_q;
    logic              we_q;
    logic [SEL_W-1:0]  idx_q;
    logic [SEL_W-1:0]  adr_idx;
    logic              adr_mapped;
    logic              sel_ack;
    logic [DATA_W-1:0] rd_mux;
    logic              timeout;

    assign adr_idx    = wb_adr_i[ADDR_W-1 -: SEL_W];
    assign adr_mapped = (32'(adr_idx) < 32'(NUM_SLAVES));

    wb_ic_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != ST_REQ),
        .enable  (state == ST_REQ),
        .timeout (timeout)
    );

    // Ack and read data from the selected slave only; other acks are ignored.
    always_comb begin
        sel_ack = 1'b0;
        rd_mux  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == SEL_W'(i)) begin
                sel_ack = s_wb_ack_i[i];
                rd_mux  = s_wb_dat_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Per-slave fan-out: only the indexed slice is driven, and only in REQ.
    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slv
        logic sel;
        assign sel = (state == ST_REQ) && (idx_q == SEL_W'(i));
        assign s_wb_cyc_o[i] = sel;
        assign s_wb_stb_o[i] = sel;
        assign s_wb_we_o[i]  = sel && we_q;
        assign s_wb_adr_o[i*ADDR_W +: ADDR_W] = sel ? adr_q : '0;
        assign s_wb_dat_o[i*DATA_W +: DATA_W] = sel ? dat_q : '0;
    end

    // Next-state decode; a dropped master cycle takes priority, then ack, then timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    state_nxt = adr_mapped ? ST_REQ : ST_ERR;
                end
            end
            ST_REQ: begin
                if (!wb_cyc_i) begin
                    state_nxt = ST_IDLE;
                end else if (sel_ack) begin
                    state_nxt = ST_RESP;
                end else if (timeout) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign wb_ack_o = (state == ST_RESP) || (state == ST_ERR);
    assign wb_err_o = (state == ST_ERR);

    // State register, request capture, read data hold and error logging.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            adr_q          <= '0;
            dat_q          <= '0;
            we_q           <= 1'b0;
            idx_q          <= '0;
            wb_dat_o       <= '0;
            err_count_o    <= '0;
            last_err_adr_o <= '0;
        end else begin
            state <= state_nxt;
            if ((state == ST_IDLE) && wb_cyc_i && wb_stb_i) begin
                adr_q <= wb_adr_i;
                dat_q <= wb_dat_i;
                we_q  <= wb_we_i;
                idx_q <= adr_idx;
            end
            // Writes leave the read data untouched; errors always return ERR_DATA.
            if ((state == ST_REQ) && (state_nxt == ST_RESP) && !we_q) begin
                wb_dat_o <= rd_mux;
            end
            if (state_nxt == ST_ERR) begin
                wb_dat_o <= ERR_DATA;
            end
            if (state == ST_ERR) begin
                if (err_count_o != 8'hFF) begin
                    err_count_o <= err_count_o + 8'd1;
                end
                last_err_adr_o <= adr_q;
            end
        end
    end

endmodule

// File: tb/tb_wb_interconnect_n.sv
// Directed bench for wb_interconnect_n: cycle-accurate checks of routing,
// latency, error termination, timeout, abort paths and counter saturation.
module tb_wb_interconnect_n;

    localparam int NS = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] wb_adr_i;
    logic [DW-1:0] wb_dat_i;
    logic [DW-1:0] wb_dat_o;
    logic          wb_cyc_i, wb_stb_i, wb_we_i;
    logic          wb_ack_o, wb_err_o;
    logic [NS*AW-1:0] s_wb_adr_o;
    logic [NS*DW-1:0] s_wb_dat_o;
    logic [NS*DW-1:0] s_wb_dat_i;
    logic [NS-1:0] s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_ack_i;
    logic [7:0]    err_count_o;
    logic [AW-1:0] last_err_adr_o;

    int total = 0;
    int bad   = 0;

    wb_interconnect_n #(
        .NUM_SLAVES  (NS),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .SEL_W       (4),
        .TIMEOUT_CYC (8),
        .ERR_DATA    (8'hEE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_adr_i       (wb_adr_i),
        .wb_dat_i       (wb_dat_i),
        .wb_dat_o       (wb_dat_o),
        .wb_cyc_i       (wb_cyc_i),
        .wb_stb_i       (wb_stb_i),
        .wb_we_i        (wb_we_i),
        .wb_ack_o       (wb_ack_o),
        .wb_err_o       (wb_err_o),
        .s_wb_adr_o     (s_wb_adr_o),
        .s_wb_dat_o     (s_wb_dat_o),
        .s_wb_dat_i     (s_wb_dat_i),
        .s_wb_cyc_o     (s_wb_cyc_o),
        .s_wb_stb_o     (s_wb_stb_o),
        .s_wb_we_o      (s_wb_we_o),
        .s_wb_ack_i     (s_wb_ack_i),
        .err_count_o    (err_count_o),
        .last_err_adr_o (last_err_adr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge and check the strobe invariant.
    task automatic step();
        @(posedge clk);
        #1;
        check("stb_onehot0", 32'($onehot0(s_wb_stb_o)), 32'd1);
    endtask

    task automatic master(input logic cyc, input logic we, input logic [7:0] adr, input logic [7:0] dat);
        wb_cyc_i = cyc;
        wb_stb_i = cyc;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
    endtask

    initial begin
        rst = 1'b1;
        master(1'b0, 1'b0, 8'h00, 8'h00);
        s_wb_dat_i = '0;
        s_wb_ack_i = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_ack",     32'(wb_ack_o), 32'd0);
        check("rst_err",     32'(wb_err_o), 32'd0);
        check("rst_dat",     32'(wb_dat_o), 32'd0);
        check("rst_cnt",     32'(err_count_o), 32'd0);
        check("rst_lastadr", 32'(last_err_adr_o), 32'd0);
        check("rst_scyc",    32'(s_wb_cyc_o), 32'd0);
        check("rst_swe",     32'(s_wb_we_o), 32'd0);

        // Write 0x2A to 0x23, slave 2 acks at k=0
        master(1'b1, 1'b1, 8'h23, 8'h2A);
        step();
        check("wr_stb_c1",  32'(s_wb_stb_o), 32'h4);
        check("wr_cyc_c1",  32'(s_wb_cyc_o), 32'h4);
        check("wr_we_c1",   32'(s_wb_we_o), 32'h4);
        check("wr_adr2",    32'(s_wb_adr_o[2*AW +: AW]), 32'h23);
        check("wr_dat2",    32'(s_wb_dat_o[2*DW +: DW]), 32'h2A);
        check("wr_adr0_0",  32'(s_wb_adr_o[0 +: AW]), 32'h00);
        check("wr_ack_c1",  32'(wb_ack_o), 32'd0);
        s_wb_ack_i = 4'b0100;
        step();
        s_wb_ack_i = 4'b0000;
        master(1'b0, 1'b0, 8'h00, 8'h00);
        check("wr_ack_c2",  32'(wb_ack_o), 32'd1);
        check("wr_err_c2",  32'(wb_err_o), 32'd0);
        check("wr_stb_c2",  32'(s_wb_stb_o), 32'h0);
        check("wr_dat_o",   32'(wb_dat_o), 32'h00);
        step();
        check("wr_ack_c3",  32'(wb_ack_o), 32'd0);

        // Read 0x11, slave 1 returns 0x5C after k=3; stray ack from slave 3 ignored
        master(1'b1, 1'b0, 8'h11, 8'h00);
        step();
        check("rd_stb_c1",  32'(s_wb_stb_o), 32'h2);
        check("rd_we_c1",   32'(s_wb_we_o), 32'h0);
        step();
        s_wb_ack_i = 4'b1000;
        s_wb_dat_i[3*DW +: DW] = 8'h99;
        step();
        s_wb_ack_i = 4'b0000;
        check("rd_stray",   32'(s_wb_stb_o), 32'h2);
        check("rd_ack_c3",  32'(wb_ack_o), 32'd0);
        step();
        s_wb_ack_i = 4'b0010;
        s_wb_dat_i[1*DW +: DW] = 8'h5C;
        step();
        s_wb_ack_i = 4'b0000;
        master(1'b0, 1'b0, 8'h00, 8'h00);
        check("rd_ack_c5",  32'(wb_ack_o), 32'd1);
        check("rd_err_c5",  32'(wb_err_o), 32'd0);
        check("rd_dat_c5",  32'(wb_dat_o), 32'h5C);
        step();
        check("rd_ack_c6",  32'(wb_ack_o), 32'd0);
        check("rd_hold",    32'(wb_dat_o), 32'h5C);

        // Reset mid-REQ: no ack, slave released, state cleared
        master(1'b1, 1'b0, 8'h15, 8'h00);
        step();
        check("rst_req_stb", 32'(s_wb_stb_o), 32'h2);
        rst = 1'b1;
        master(1'b0, 1'b0, 8'h00, 8'h00);
        step();
        rst = 1'b0;
        check("rst_req_rel", 32'(s_wb_stb_o), 32'h0);
        check("rst_req_ack", 32'(wb_ack_o), 32'd0);
        check("rst_req_dat", 32'(wb_dat_o), 32'h00);
        check("rst_req_cnt", 32'(err_count_o), 32'd0);
        step();
        check("rst_req_ack2", 32'(wb_ack_o), 32'd0);

        // Unmapped read 0x47
        master(1'b1, 1'b0, 8'h47, 8'h00);
        step();
        check("um_stb",     32'(s_wb_stb_o), 32'h0);
        check("um_ack",     32'(wb_ack_o), 32'd1);
        check("um_err",     32'(wb_err_o), 32'd1);
        check("um_dat",     32'(wb_dat_o), 32'hEE);
        master(1'b0, 1'b0, 8'h00, 8'h00);
        step();
        check("um_ack2",    32'(wb_ack_o), 32'd0);
        check("um_cnt",     32'(err_count_o), 32'd1);
        check("um_last",    32'(last_err_adr_o), 32'h47);

        // Timeout: slave 0 never acks, 8 REQ cycles then ERR
        master(1'b1, 1'b0, 8'h05, 8'h00);
        for (int i = 1; i <= 8; i++) begin
            step();
            check("to_stb",  32'(s_wb_stb_o), 32'h1);
            check("to_noack", 32'(wb_ack_o), 32'd0);
        end
        step();
        check("to_rel",     32'(s_wb_stb_o), 32'h0);
        check("to_ack",     32'(wb_ack_o), 32'd1);
        check("to_err",     32'(wb_err_o), 32'd1);
        check("to_dat",     32'(wb_dat_o), 32'hEE);
        master(1'b0, 1'b0, 8'h00, 8'h00);
        step();
        check("to_cnt",     32'(err_count_o), 32'd2);
        check("to_last",    32'(last_err_adr_o), 32'h05);

        // Master drops cyc in REQ: slave released, no ack, nothing counted
        master(1'b1, 1'b1, 8'h32, 8'h61);
        step();
        check("drop_stb",   32'(s_wb_stb_o), 32'h8);
        check("drop_we",    32'(s_wb_we_o), 32'h8);
        master(1'b0, 1'b0, 8'h00, 8'h00);
        step();
        check("drop_rel",   32'(s_wb_stb_o), 32'h0);
        check("drop_ack",   32'(wb_ack_o), 32'd0);
        step();
        check("drop_ack2",  32'(wb_ack_o), 32'd0);
        check("drop_cnt",   32'(err_count_o), 32'd2);

        // Back-to-back: read 0x01 from slave 0, then stb held to 0x31 (slave 3)
        master(1'b1, 1'b0, 8'h01, 8'h00);
        step();
        check("b2b_stb1",   32'(s_wb_stb_o), 32'h1);
        s_wb_ack_i = 4'b0001;
        s_wb_dat_i[0 +: DW] = 8'h77;
        step();
        s_wb_ack_i = 4'b0000;
        check("b2b_ack1",   32'(wb_ack_o), 32'd1);
        check("b2b_dat1",   32'(wb_dat_o), 32'h77);
        master(1'b1, 1'b0, 8'h31, 8'h00);
        step();
        check("b2b_idle",   32'(s_wb_stb_o), 32'h0);
        check("b2b_noack",  32'(wb_ack_o), 32'd0);
        step();
        check("b2b_stb2",   32'(s_wb_stb_o), 32'h8);
        check("b2b_adr3",   32'(s_wb_adr_o[3*AW +: AW]), 32'h31);
        s_wb_ack_i = 4'b1000;
        s_wb_dat_i[3*DW +: DW] = 8'hA5;
        step();
        s_wb_ack_i = 4'b0000;
        master(1'b0, 1'b0, 8'h00, 8'h00);
        check("b2b_ack2",   32'(wb_ack_o), 32'd1);
        check("b2b_dat2",   32'(wb_dat_o), 32'hA5);
        step();

        // Saturation: unmapped 0xF0 held continuously, one error every 2 cycles
        master(1'b1, 1'b0, 8'hF0, 8'h00);
        for (int i = 0; i < 20; i++) step();
        check("sat_cnt12",  32'(err_count_o), 32'd12);
        for (int i = 0; i < 580; i++) step();
        master(1'b0, 1'b0, 8'h00, 8'h00);
        step();
        check("sat_cnt",    32'(err_count_o), 32'd255);
        check("sat_last",   32'(last_err_adr_o), 32'hF0);
        check("sat_ack",    32'(wb_ack_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
